// File: rtl/prog_run_ctrl.sv
// Run controller for the 16-bit proc and its 2-port RAM: streams a program image into
// RAM port 0, runs proc until a halt pc or a cycle timeout, then streams the RAM image out.
module prog_run_ctrl #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 7,
  parameter int LOAD_WORDS = 128,
  parameter int HALT_PC    = 10,
  parameter int HALT_DELAY = 3,
  parameter int TMO_W      = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_go,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] pc,
  input  logic              prog_re,
  output logic              proc_rst_n,
  output logic              proc_start,
  output logic              ram_re0,
  output logic              ram_we0,
  output logic [ADDR_W-1:0] ram_addr0,
  output logic [DATA_W-1:0] ram_din0,
  input  logic [DATA_W-1:0] ram_dout0,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  input  logic              dump_ready,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [TMO_W-1:0]  run_cycles
);

  localparam int DLY_W = (HALT_DELAY < 2) ? 1 : $clog2(HALT_DELAY + 1);
  localparam logic [ADDR_W-1:0] LAST_LOAD = ADDR_W'(LOAD_WORDS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(HALT_PC);
  localparam logic [DLY_W-1:0]  DLY_INIT  = DLY_W'(HALT_DELAY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DUMP_RD,
    S_DUMP_WT,
    S_DONE
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  idx;
  logic [DLY_W-1:0]   dly;
  logic [TMO_W-1:0]   run_next;
  logic               halt_hit;
  logic               load_acc;

  assign run_next = run_cycles + 1'b1;
  assign halt_hit = (pc == HALT_ADDR);
  assign load_acc = load_ready & load_valid;

  // Port 0 belongs to proc while it runs, so its mux follows state combinationally.
  always_comb begin
    load_ready = 1'b0;
    proc_rst_n = 1'b0;
    proc_start = 1'b0;
    ram_re0    = 1'b0;
    ram_we0    = 1'b0;
    ram_addr0  = '0;
    ram_din0   = '0;
    busy       = !(state == S_IDLE || state == S_DONE);
    done       = (state == S_DONE);
    case (state)
      S_LOAD: begin
        load_ready = 1'b1;
        ram_we0    = load_valid;
        ram_addr0  = idx;
        ram_din0   = load_data;
      end
      S_RUN, S_DRAIN: begin
        proc_rst_n = 1'b1;
        proc_start = 1'b1;
        ram_re0    = prog_re;
        ram_addr0  = pc;
      end
      S_DUMP_RD: begin
        ram_re0   = 1'b1;
        ram_addr0 = idx;
      end
      S_DUMP_WT: ram_addr0 = idx;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      dly        <= '0;
      run_cycles <= '0;
      timeout    <= 1'b0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (cmd_go) begin
            state      <= S_LOAD;
            idx        <= '0;
            timeout    <= 1'b0;
            run_cycles <= '0;
          end
        end
        S_LOAD: begin
          if (load_acc) begin
            idx <= idx + 1'b1;
            if (idx == LAST_LOAD) state <= S_RUN;
          end
        end
        // DRAIN spans exactly HALT_DELAY cycles after the halt/timeout cycle; skipped when 0.
        S_RUN: begin
          run_cycles <= run_next;
          if (halt_hit || run_next == '1) begin
            timeout <= !halt_hit;
            dly     <= DLY_INIT;
            idx     <= '0;
            state   <= (HALT_DELAY == 0) ? S_DUMP_RD : S_DRAIN;
          end
        end
        S_DRAIN: begin
          dly <= dly - 1'b1;
          if (dly == DLY_W'(1)) begin
            state <= S_DUMP_RD;
            idx   <= '0;
          end
        end
        S_DUMP_RD: state <= S_DUMP_WT;
        S_DUMP_WT: begin
          if (!dump_valid) begin
            dump_valid <= 1'b1;
            dump_data  <= ram_dout0;
            dump_addr  <= idx;
          end else if (dump_ready) begin
            dump_valid <= 1'b0;
            if (idx == LAST_ADDR) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_DUMP_RD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Scoreboard bench for prog_run_ctrl: expected RAM writes and dump words are queued as
// load words are accepted, then popped as the DUT writes port 0 and presents dump words.
module tb_prog_run_ctrl;

  localparam int DW = 16;
  localparam int AW = 7;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_go;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic [AW-1:0] pc;
  logic          prog_re;
  logic          proc_rst_n;
  logic          proc_start;
  logic          ram_re0;
  logic          ram_we0;
  logic [AW-1:0] ram_addr0;
  logic [DW-1:0] ram_din0;
  logic [DW-1:0] ram_dout0;
  logic          dump_valid;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          dump_ready;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [TW-1:0] run_cycles;

  prog_run_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .LOAD_WORDS(128), .HALT_PC(10), .HALT_DELAY(3), .TMO_W(TW)
  ) dut (
    .clk(clk), .reset(reset), .cmd_go(cmd_go),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .pc(pc), .prog_re(prog_re), .proc_rst_n(proc_rst_n), .proc_start(proc_start),
    .ram_re0(ram_re0), .ram_we0(ram_we0), .ram_addr0(ram_addr0), .ram_din0(ram_din0),
    .ram_dout0(ram_dout0),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_ready(dump_ready),
    .busy(busy), .done(done), .timeout(timeout), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:127];
  always @(posedge clk) begin
    if (ram_we0) mem[ram_addr0] <= ram_din0;
    if (ram_re0) ram_dout0 <= mem[ram_addr0];
  end

  logic [63:0] outs;
  assign outs = 64'({busy, done, timeout, proc_rst_n, proc_start, load_ready, dump_valid,
                     ram_re0, ram_we0, ram_addr0, ram_din0, dump_addr, dump_data, run_cycles});

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int dump_count = 0;
  int stall_cnt = 0;
  bit stall_en = 1'b0;
  int n;
  logic [AW+DW-1:0] exp_wr[$];
  logic [AW+DW-1:0] exp_dump[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    cmd_go = 1'b1;
    tick();
    cmd_go = 1'b0;
  endtask

  // Returns at the start of the first RUN cycle.
  task automatic load_image(input bit toggle, input int kind);
    int unsigned i;
    logic [DW-1:0] w;
    i = 0;
    wr_count = 0;
    go();
    for (int unsigned cyc = 0; cyc < 1000 && i < 128; cyc++) begin
      w = (kind == 0) ? DW'(i * 3) : (kind == 1) ? ~DW'(i) : DW'(i * 5 + 1);
      load_valid = toggle ? ~cyc[0] : 1'b1;
      load_data  = w;
      #2;
      if (load_valid && load_ready) begin
        exp_wr.push_back({AW'(i), w});
        exp_dump.push_back({AW'(i), w});
        i++;
      end
      tick();
    end
    load_valid = 1'b0;
    check("load_words", i, 128);
    check("wr_count", wr_count, 128);
    check("wr_queue_left", exp_wr.size(), 0);
  endtask

  task automatic finish_dump();
    int k;
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("done_flags", {done, busy}, 2'b10);
    check("dump_count", dump_count, 128);
    check("dump_queue_left", exp_dump.size(), 0);
    dump_count = 0;
  endtask

  // Write/dump monitor, sampled mid-cycle.
  initial begin
    logic [AW+DW-1:0] e;
    logic hold_pend;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;
    hold_pend = 1'b0;
    hold_addr = '0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (ram_we0) begin
        wr_count++;
        check("wr_pending", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          check("wr_addr", ram_addr0, e[AW+DW-1:DW]);
          check("wr_data", ram_din0, e[DW-1:0]);
        end
      end
      if (hold_pend) begin
        check("hold_valid", dump_valid, 1);
        check("hold_addr", dump_addr, hold_addr);
        check("hold_data", dump_data, hold_data);
      end
      hold_pend = dump_valid & ~dump_ready;
      hold_addr = dump_addr;
      hold_data = dump_data;
      if (dump_valid && dump_ready) begin
        dump_count++;
        check("dump_pending", exp_dump.size() != 0, 1);
        if (exp_dump.size() != 0) begin
          e = exp_dump.pop_front();
          check("dump_addr", dump_addr, e[AW+DW-1:DW]);
          check("dump_data", dump_data, e[DW-1:0]);
        end
      end
    end
  end

  // Dump sink: always ready except a 5-cycle stall on word 7 when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_en && dump_valid && dump_addr == AW'(7) && stall_cnt < 5) begin
        dump_ready = 1'b0;
        stall_cnt++;
      end else begin
        dump_ready = 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cmd_go = 1'b0; load_valid = 1'b0; load_data = '0;
    pc = '0; prog_re = 1'b0; dump_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_outs", outs, 0);

    // Load words outside LOAD are ignored.
    tick();
    load_valid = 1'b1;
    load_data  = 16'hdead;
    @(negedge clk);
    check("idle_ready", {load_ready, ram_we0}, 2'b00);
    tick();
    load_valid = 1'b0;

    // Run A: contiguous load of i*3, halt at RUN cycle 5.
    load_image(1'b0, 0);
    @(negedge clk);
    check("run_entry", {proc_rst_n, proc_start, busy}, 3'b111);
    tick();
    for (int c = 1; c < 5; c++) begin
      pc = AW'(c + 20);
      prog_re = c[0];
      @(negedge clk);
      check("run_mux", {ram_addr0, ram_re0, ram_we0}, {pc, prog_re, 1'b0});
      tick();
    end
    pc = AW'(10);
    prog_re = 1'b0;
    tick();
    pc = '0;
    n = 0;
    @(negedge clk);
    while (proc_rst_n && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("drain_cycles", n, 3);
    check("halt_state", {proc_rst_n, timeout, run_cycles}, {1'b0, 1'b0, 4'd6});
    finish_dump();

    // Run B: toggled load of ~i, pc never halts, stalled dump sink.
    tick();
    stall_en = 1'b1;
    stall_cnt = 0;
    load_image(1'b1, 1);
    n = 0;
    @(negedge clk);
    while (proc_rst_n && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("tmo_run_drain", n, 18);
    check("tmo_state", {timeout, run_cycles}, {1'b1, 4'd15});
    finish_dump();
    check("stall_cycles", stall_cnt, 5);
    check("tmo_sticky", timeout, 1);
    stall_en = 1'b0;

    // Run C: restart from DONE, reset while word 40 is presented.
    tick();
    load_image(1'b0, 2);
    pc = AW'(10);
    @(negedge clk);
    check("tmo_cleared", timeout, 0);
    tick();
    pc = '0;
    n = 0;
    while (!(dump_valid && dump_addr == AW'(40)) && n < 1000) begin
      tick();
      n++;
    end
    check("reach_word40", dump_valid && dump_addr == AW'(40), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_outs", outs, 0);
    exp_dump.delete();
    dump_count = 0;

    // Run D: cmd_go after reset starts the load again at index 0.
    tick();
    load_image(1'b0, 0);
    pc = AW'(10);
    tick();
    pc = '0;
    finish_dump();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
